// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding instruction port feeding a small prefetch FIFO.
// Optional feature macro: FETCH_MISALIGN_EXC_EN (misaligned redirect raises an exception entry).
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] iport_addr_o,
  output logic        iport_cyc_o,
  output logic        iport_stb_o,
  input  logic [31:0] iport_dat_i,
  input  logic        iport_ack_i,
  input  logic        iport_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        e_inst_access_fault_o,
  output logic        e_inst_addr_misaligned_o
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {IDLE, BUSY, DISCARD, DRAIN_HALT, HALT} state_t;

  state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q, wr_idx;
  logic [CW-1:0] count_q;
  logic [31:0] pc_mem [FIFO_DEPTH];
  logic [31:0] instr_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fault_mem;
  logic push, pop, flush, xfer_done, push_fault, push_mis;
  logic [31:0] push_pc, push_instr;
  logic [31:0] target;
  logic target_misaligned;

  assign xfer_done    = iport_ack_i || iport_err_i;
  assign iport_cyc_o  = (state_q == BUSY) || (state_q == DISCARD) || (state_q == DRAIN_HALT);
  assign iport_stb_o  = iport_cyc_o;
  assign iport_addr_o = addr_q;
  assign valid_o      = (count_q != '0);
  assign pop          = valid_o && !stall_i && !redirect_i;
  assign wr_idx       = flush ? '0 : wr_ptr_q;

  assign instruction_o         = valid_o ? instr_mem[rd_ptr_q] : '0;
  assign pc_o                  = valid_o ? pc_mem[rd_ptr_q] : '0;
  assign e_inst_access_fault_o = valid_o && fault_mem[rd_ptr_q];

`ifdef FETCH_MISALIGN_EXC_EN
  logic [FIFO_DEPTH-1:0] mis_mem;
  assign target            = redirect_pc_i;
  assign target_misaligned = (redirect_pc_i[1:0] != 2'b00);
  assign e_inst_addr_misaligned_o = valid_o && mis_mem[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mis_mem <= '0;
    else if (push) mis_mem[wr_idx] <= push_mis;
  end
`else
  logic unused_low_bits;
  assign target            = {redirect_pc_i[31:2], 2'b00};
  assign target_misaligned = 1'b0;
  assign unused_low_bits   = ^{redirect_pc_i[1:0], push_mis};
  assign e_inst_addr_misaligned_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    flush      = 1'b0;
    push       = 1'b0;
    push_pc    = fetch_pc_q;
    push_instr = iport_dat_i;
    push_fault = 1'b0;
    push_mis   = 1'b0;
    if (redirect_i) begin
      // An outstanding cycle must still be absorbed before anything new is issued.
      flush      = 1'b1;
      fetch_pc_d = target;
      if (target_misaligned) begin
        push       = 1'b1;
        push_pc    = target;
        push_instr = NOP;
        push_mis   = 1'b1;
        state_d    = (iport_cyc_o && !xfer_done) ? DRAIN_HALT : HALT;
      end else begin
        state_d = (iport_cyc_o && !xfer_done) ? DISCARD : IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q < CW'(FIFO_DEPTH)) begin
            state_d = BUSY;
            addr_d  = fetch_pc_q;
          end
        end
        BUSY: begin
          if (iport_ack_i) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = IDLE;
          end else if (iport_err_i) begin
            push       = 1'b1;
            push_instr = NOP;
            push_fault = 1'b1;
            state_d    = HALT;
          end
        end
        DISCARD:    if (xfer_done) state_d = IDLE;
        DRAIN_HALT: if (xfer_done) state_d = HALT;
        default:    state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_ADDR;
      addr_q     <= RESET_ADDR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      fault_mem <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        pc_mem[wr_idx]    <= push_pc;
        instr_mem[wr_idx] <= push_instr;
        fault_mem[wr_idx] <= push_fault;
      end
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= push ? PW'(1) : '0;
        count_q  <= push ? CW'(1) : '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized stream vs. a PC-sequence model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] iport_addr, iport_dat = '0;
  logic        iport_cyc, iport_stb;
  logic        iport_ack = 1'b0, iport_err = 1'b0;
  logic        redirect = 1'b0, stall = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instruction, pc;
  logic        valid, fault, misaligned;

  int total = 0;
  int bad = 0;

  logic [31:0] err_addr = '1;
  int slave_wait = 0;
  bit rand_wait = 1'b0;
  int ack_count = 0;
  int waited = 0;
  int cur_wait = 0;
  bit new_xfer = 1'b1;

  fetch_unit #(.RESET_ADDR(32'h8000_0000), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .iport_addr_o(iport_addr), .iport_cyc_o(iport_cyc), .iport_stb_o(iport_stb),
    .iport_dat_i(iport_dat), .iport_ack_i(iport_ack), .iport_err_i(iport_err),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_i(stall),
    .instruction_o(instruction), .pc_o(pc), .valid_o(valid),
    .e_inst_access_fault_o(fault), .e_inst_addr_misaligned_o(misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h00A0_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Bus slave: responds after cur_wait wait states, one response per transfer.
  always begin
    @(posedge clk);
    #1;
    if (rst || iport_ack || iport_err) begin
      iport_ack = 1'b0;
      iport_err = 1'b0;
      waited = 0;
      new_xfer = 1'b1;
    end else if (iport_cyc) begin
      if (new_xfer) begin
        cur_wait = rand_wait ? int'($urandom_range(0, 3)) : slave_wait;
        new_xfer = 1'b0;
      end
      if (waited >= cur_wait) begin
        if (iport_addr == err_addr) begin
          iport_err = 1'b1;
          iport_dat = 32'hDEAD_BEEF;
        end else begin
          iport_ack = 1'b1;
          iport_dat = mem_word(iport_addr);
        end
        ack_count++;
      end else begin
        waited++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    slave_wait = 3;
    do_reset();
    repeat (2) @(negedge clk);
    total++; if (iport_cyc !== 1'b1) begin bad++; $display("FAIL rst_pre_cyc got=%b want=1", iport_cyc); end
    rst = 1'b1;
    #1;
    total++; if (iport_cyc !== 1'b0) begin bad++; $display("FAIL rst_cyc got=%b want=0", iport_cyc); end
    total++; if (iport_stb !== 1'b0) begin bad++; $display("FAIL rst_stb got=%b want=0", iport_stb); end
    total++; if (iport_addr !== 32'h8000_0000) begin bad++; $display("FAIL rst_addr got=%h want=80000000", iport_addr); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", valid); end
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", instruction); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", pc); end
    total++; if ({fault, misaligned} !== 2'b00) begin bad++; $display("FAIL rst_exc got=%b want=00", {fault, misaligned}); end
  endtask

  task automatic test_first_fetch();
    slave_wait = 0;
    do_reset();
    @(negedge clk);
    total++; if (iport_cyc !== 1'b1 || iport_addr !== 32'h8000_0000) begin bad++; $display("FAIL first_req got=%b/%h want=1/80000000", iport_cyc, iport_addr); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL first_early_valid got=%b want=0", valid); end
    @(negedge clk);
    total++; if (valid !== 1'b1 || pc !== 32'h8000_0000) begin bad++; $display("FAIL first_entry got=%b/%h want=1/80000000", valid, pc); end
    total++; if (instruction !== 32'h00A0_0093) begin bad++; $display("FAIL first_instr got=%h want=00a00093", instruction); end
    @(negedge clk);
    total++; if (iport_cyc !== 1'b1 || iport_addr !== 32'h8000_0004) begin bad++; $display("FAIL second_req got=%b/%h want=1/80000004", iport_cyc, iport_addr); end
  endtask

  task automatic test_stall();
    int acks0;
    slave_wait = 0;
    do_reset();
    stall = 1'b1;
    acks0 = ack_count;
    repeat (10) @(negedge clk);
    total++; if (ack_count - acks0 != 2) begin bad++; $display("FAIL stall_acks got=%0d want=2", ack_count - acks0); end
    total++; if (iport_cyc !== 1'b0) begin bad++; $display("FAIL stall_cyc got=%b want=0", iport_cyc); end
    total++; if (valid !== 1'b1 || pc !== 32'h8000_0000) begin bad++; $display("FAIL stall_head got=%b/%h want=1/80000000", valid, pc); end
    stall = 1'b0;
    @(negedge clk);
    total++; if (valid !== 1'b1 || pc !== 32'h8000_0004 || iport_cyc !== 1'b0) begin bad++; $display("FAIL stall_second got=%b/%h/%b want=1/80000004/0", valid, pc, iport_cyc); end
    @(negedge clk);
    total++; if (valid !== 1'b0 || iport_cyc !== 1'b1 || iport_addr !== 32'h8000_0008) begin bad++; $display("FAIL stall_resume got=%b/%b/%h want=0/1/80000008", valid, iport_cyc, iport_addr); end
  endtask

  task automatic test_redirect_discard();
    bit found = 0, stale = 0, got = 0, addr_seen = 0;
    logic [31:0] new_addr = '0, got_instr = '0;
    slave_wait = 3;
    do_reset();
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (iport_cyc && iport_addr == 32'h8000_0008) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL discard_setup got=0 want=1"); end
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (valid && pc != 32'h0000_0100) stale = 1;
      if (iport_cyc && iport_addr != 32'h8000_0008 && !addr_seen) begin
        addr_seen = 1;
        new_addr = iport_addr;
      end
      if (valid && pc == 32'h0000_0100) begin
        got = 1;
        got_instr = instruction;
      end
      @(negedge clk);
    end
    total++; if (stale) begin bad++; $display("FAIL discard_stale got=1 want=0"); end
    total++; if (new_addr !== 32'h0000_0100) begin bad++; $display("FAIL discard_next_addr got=%h want=00000100", new_addr); end
    total++; if (!got || got_instr !== mem_word(32'h100)) begin bad++; $display("FAIL discard_target got=%b/%h want=1/%h", got, got_instr, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_with_ack();
    slave_wait = 0;
    do_reset();
    for (int i = 0; i < 10 && !iport_cyc; i++) @(negedge clk);
    total++; if (iport_ack !== 1'b1) begin bad++; $display("FAIL racksetup got=%b want=1", iport_ack); end
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect = 1'b0;
    total++; if (valid !== 1'b0 || iport_cyc !== 1'b0) begin bad++; $display("FAIL rack_dropped got=%b/%b want=0/0", valid, iport_cyc); end
    @(negedge clk);
    total++; if (iport_cyc !== 1'b1 || iport_addr !== 32'h0000_0200) begin bad++; $display("FAIL rack_req got=%b/%h want=1/00000200", iport_cyc, iport_addr); end
    @(negedge clk);
    total++; if (valid !== 1'b1 || pc !== 32'h0000_0200) begin bad++; $display("FAIL rack_entry got=%b/%h want=1/00000200", valid, pc); end
  endtask

  task automatic test_fault();
    bit found = 0, busy = 0;
    slave_wait = 0;
    err_addr = 32'h8000_0010;
    do_reset();
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (valid && pc == 32'h8000_0010) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL fault_entry got=0 want=1"); end
    total++; if (fault !== 1'b1 || instruction !== 32'h13) begin bad++; $display("FAIL fault_flags got=%b/%h want=1/00000013", fault, instruction); end
    repeat (10) begin
      @(negedge clk);
      if (iport_cyc) busy = 1;
    end
    total++; if (busy) begin bad++; $display("FAIL fault_halt got=1 want=0"); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL fault_drain got=%b want=0", valid); end
    redirect = 1'b1;
    redirect_pc = 32'h8000_0000;
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 10 && !iport_cyc; i++) @(negedge clk);
    total++; if (iport_cyc !== 1'b1 || iport_addr !== 32'h8000_0000) begin bad++; $display("FAIL fault_resume got=%b/%h want=1/80000000", iport_cyc, iport_addr); end
    err_addr = '1;
  endtask

  task automatic test_misaligned();
    slave_wait = 0;
    do_reset();
    stall = 1'b1;
    repeat (8) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_EXC_EN
    begin
      bit busy = 0;
      total++; if (valid !== 1'b1 || misaligned !== 1'b1 || fault !== 1'b0) begin bad++; $display("FAIL mis_flags got=%b/%b/%b want=1/1/0", valid, misaligned, fault); end
      total++; if (pc !== 32'h0000_0102 || instruction !== 32'h13) begin bad++; $display("FAIL mis_entry got=%h/%h want=00000102/00000013", pc, instruction); end
      stall = 1'b0;
      repeat (6) begin
        if (iport_cyc) busy = 1;
        @(negedge clk);
      end
      total++; if (busy) begin bad++; $display("FAIL mis_nobus got=1 want=0"); end
    end
`else
    total++; if (valid !== 1'b0 || misaligned !== 1'b0) begin bad++; $display("FAIL mis_flush got=%b/%b want=0/0", valid, misaligned); end
    for (int i = 0; i < 10 && !iport_cyc; i++) @(negedge clk);
    total++; if (iport_cyc !== 1'b1 || iport_addr !== 32'h0000_0100) begin bad++; $display("FAIL mis_forced got=%b/%h want=1/00000100", iport_cyc, iport_addr); end
    @(negedge clk);
    total++; if (valid !== 1'b1 || pc !== 32'h0000_0100 || misaligned !== 1'b0) begin bad++; $display("FAIL mis_forced_entry got=%b/%h/%b want=1/00000100/0", valid, pc, misaligned); end
`endif
    stall = 1'b0;
  endtask

  // Reference: after reset or a redirect, delivered PCs run target, +4, +4 ... until
  // the faulting address is delivered, after which nothing more may appear.
  task automatic test_random();
    logic [31:0] exp_pc = 32'h8000_0000;
    logic [31:0] exp_instr;
    bit halted = 0;
    bit exp_fault;
    int deliveries = 0;
    rand_wait = 1'b1;
    err_addr = 32'h4000_0020;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 49) == 0);
      redirect_pc = 32'h4000_0000 + ($urandom_range(0, 15) << 2);
      total++; if (iport_stb !== iport_cyc) begin bad++; $display("FAIL rnd_stb got=%b want=%b", iport_stb, iport_cyc); end
      if (valid && !stall && !redirect) begin
        deliveries++;
        exp_fault = (exp_pc == err_addr);
        exp_instr = exp_fault ? 32'h13 : mem_word(exp_pc);
        total++; if (halted) begin bad++; $display("FAIL rnd_after_halt got=%h want=none", pc); end
        total++; if (pc !== exp_pc) begin bad++; $display("FAIL rnd_pc got=%h want=%h", pc, exp_pc); end
        total++; if (instruction !== exp_instr) begin bad++; $display("FAIL rnd_instr got=%h want=%h", instruction, exp_instr); end
        total++; if (fault !== exp_fault) begin bad++; $display("FAIL rnd_fault got=%b want=%b", fault, exp_fault); end
        if (exp_fault) halted = 1;
        else exp_pc = exp_pc + 32'd4;
      end
      if (redirect) begin
        exp_pc = redirect_pc;
        halted = 0;
      end
      @(negedge clk);
    end
    redirect = 1'b0;
    stall = 1'b0;
    rand_wait = 1'b0;
    err_addr = '1;
    total++; if (deliveries < 100) begin bad++; $display("FAIL rnd_progress got=%0d want=>=100", deliveries); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_discard();
    test_redirect_with_ack();
    test_fault();
    test_misaligned();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
